// File: rtl/id_decode_stage.sv
// RV32I decode into the ID/EX register; one-cycle latency, aligned with the register-file read.
// Backpressure: if_ready drops only for a single load-use bubble. A flush always consumes the incoming word.
module id_decode_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   input  logic        flush,
   output logic [4:0]  rf_rs1,
   output logic [4:0]  rf_rs2,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [31:0] ex_imm,
   output logic [3:0]  ex_alu_op,
   output logic [2:0]  ex_funct3,
   output logic        ex_use_imm,
   output logic        ex_use_pc,
   output logic        ex_reg_we,
   output logic        ex_is_load,
   output logic        ex_is_store,
   output logic        ex_is_branch,
   output logic        ex_is_jal,
   output logic        ex_is_jalr,
   output logic        ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   // Register-immediate forms never produce SUB, so allow_sub gates the i[30] qualifier on funct3=0.
   function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt, input logic allow_sub);
      logic [3:0] op;
      case (f3)
         3'd0:    op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  dec_funct3;
   logic [4:0]  dec_rd;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   logic [31:0] dec_imm;
   logic [3:0]  dec_alu_op;
   logic        dec_use_imm;
   logic        dec_use_pc;
   logic        dec_we_raw;
   logic        dec_reg_we;
   logic        dec_is_load;
   logic        dec_is_store;
   logic        dec_is_branch;
   logic        dec_is_jal;
   logic        dec_is_jalr;
   logic        dec_illegal;
   logic        dec_uses_rs1;
   logic        dec_uses_rs2;

   logic        load_use;
   logic        capture;

   logic        ex_valid_q,     ex_valid_d;
   logic [31:0] ex_pc_q,        ex_pc_d;
   logic [4:0]  ex_rd_q,        ex_rd_d;
   logic [4:0]  ex_rs1_q,       ex_rs1_d;
   logic [4:0]  ex_rs2_q,       ex_rs2_d;
   logic [31:0] ex_imm_q,       ex_imm_d;
   logic [3:0]  ex_alu_op_q,    ex_alu_op_d;
   logic [2:0]  ex_funct3_q,    ex_funct3_d;
   logic        ex_use_imm_q,   ex_use_imm_d;
   logic        ex_use_pc_q,    ex_use_pc_d;
   logic        ex_reg_we_q,    ex_reg_we_d;
   logic        ex_is_load_q,   ex_is_load_d;
   logic        ex_is_store_q,  ex_is_store_d;
   logic        ex_is_branch_q, ex_is_branch_d;
   logic        ex_is_jal_q,    ex_is_jal_d;
   logic        ex_is_jalr_q,   ex_is_jalr_d;
   logic        ex_illegal_q,   ex_illegal_d;

   assign opcode     = if_instr[6:0];
   assign dec_funct3 = if_instr[14:12];
   assign dec_rd     = if_instr[11:7];
   assign rf_rs1     = if_instr[19:15];
   assign rf_rs2     = if_instr[24:20];

   assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u = {if_instr[31:12], 12'b0};
   assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

   always_comb begin
      dec_imm       = 32'd0;
      dec_alu_op    = ALU_ADD;
      dec_use_imm   = 1'b0;
      dec_use_pc    = 1'b0;
      dec_we_raw    = 1'b0;
      dec_is_load   = 1'b0;
      dec_is_store  = 1'b0;
      dec_is_branch = 1'b0;
      dec_is_jal    = 1'b0;
      dec_is_jalr   = 1'b0;
      dec_illegal   = 1'b0;
      dec_uses_rs1  = 1'b0;
      dec_uses_rs2  = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec_imm     = imm_u;
            dec_alu_op  = ALU_PASSB;
            dec_use_imm = 1'b1;
            dec_we_raw  = 1'b1;
         end
         OPC_AUIPC: begin
            dec_imm     = imm_u;
            dec_use_pc  = 1'b1;
            dec_use_imm = 1'b1;
            dec_we_raw  = 1'b1;
         end
         // Jumps compute the link address pc+4 in the ALU; the target adder uses ex_imm separately.
         OPC_JAL: begin
            dec_imm    = imm_j;
            dec_use_pc = 1'b1;
            dec_we_raw = 1'b1;
            dec_is_jal = 1'b1;
         end
         OPC_JALR: begin
            dec_imm      = imm_i;
            dec_use_pc   = 1'b1;
            dec_we_raw   = 1'b1;
            dec_is_jalr  = 1'b1;
            dec_uses_rs1 = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm       = imm_b;
            dec_alu_op    = ALU_SUB;
            dec_is_branch = 1'b1;
            dec_uses_rs1  = 1'b1;
            dec_uses_rs2  = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm      = imm_i;
            dec_use_imm  = 1'b1;
            dec_we_raw   = 1'b1;
            dec_is_load  = 1'b1;
            dec_uses_rs1 = 1'b1;
         end
         OPC_STORE: begin
            dec_imm      = imm_s;
            dec_use_imm  = 1'b1;
            dec_is_store = 1'b1;
            dec_uses_rs1 = 1'b1;
            dec_uses_rs2 = 1'b1;
         end
         OPC_OPIMM: begin
            dec_imm      = imm_i;
            dec_alu_op   = f3_to_alu(dec_funct3, if_instr[30], 1'b0);
            dec_use_imm  = 1'b1;
            dec_we_raw   = 1'b1;
            dec_uses_rs1 = 1'b1;
         end
         OPC_OP: begin
            dec_alu_op   = f3_to_alu(dec_funct3, if_instr[30], 1'b1);
            dec_we_raw   = 1'b1;
            dec_uses_rs1 = 1'b1;
            dec_uses_rs2 = 1'b1;
         end
         OPC_FENCE, OPC_SYSTEM: begin
            dec_we_raw = 1'b0;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign dec_reg_we = dec_we_raw && (dec_rd != 5'd0);

   // A load in EX has no data until writeback; hold the consumer one cycle so the RF re-read sees it.
   assign load_use = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && if_valid &&
                     ((dec_uses_rs1 && (rf_rs1 == ex_rd_q)) || (dec_uses_rs2 && (rf_rs2 == ex_rd_q)));

   assign if_ready = flush || !load_use;
   assign capture  = !flush && !load_use && if_valid;

   always_comb begin
      ex_valid_d     = capture;
      ex_pc_d        = capture ? if_pc         : ex_pc_q;
      ex_rd_d        = capture ? dec_rd        : ex_rd_q;
      ex_rs1_d       = capture ? rf_rs1        : ex_rs1_q;
      ex_rs2_d       = capture ? rf_rs2        : ex_rs2_q;
      ex_imm_d       = capture ? dec_imm       : ex_imm_q;
      ex_alu_op_d    = capture ? dec_alu_op    : ex_alu_op_q;
      ex_funct3_d    = capture ? dec_funct3    : ex_funct3_q;
      ex_use_imm_d   = capture ? dec_use_imm   : ex_use_imm_q;
      ex_use_pc_d    = capture ? dec_use_pc    : ex_use_pc_q;
      ex_reg_we_d    = capture ? dec_reg_we    : ex_reg_we_q;
      ex_is_load_d   = capture ? dec_is_load   : ex_is_load_q;
      ex_is_store_d  = capture ? dec_is_store  : ex_is_store_q;
      ex_is_branch_d = capture ? dec_is_branch : ex_is_branch_q;
      ex_is_jal_d    = capture ? dec_is_jal    : ex_is_jal_q;
      ex_is_jalr_d   = capture ? dec_is_jalr   : ex_is_jalr_q;
      ex_illegal_d   = capture ? dec_illegal   : ex_illegal_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_pc_q        <= 32'd0;
         ex_rd_q        <= 5'd0;
         ex_rs1_q       <= 5'd0;
         ex_rs2_q       <= 5'd0;
         ex_imm_q       <= 32'd0;
         ex_alu_op_q    <= 4'd0;
         ex_funct3_q    <= 3'd0;
         ex_use_imm_q   <= 1'b0;
         ex_use_pc_q    <= 1'b0;
         ex_reg_we_q    <= 1'b0;
         ex_is_load_q   <= 1'b0;
         ex_is_store_q  <= 1'b0;
         ex_is_branch_q <= 1'b0;
         ex_is_jal_q    <= 1'b0;
         ex_is_jalr_q   <= 1'b0;
         ex_illegal_q   <= 1'b0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_pc_q        <= ex_pc_d;
         ex_rd_q        <= ex_rd_d;
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         ex_imm_q       <= ex_imm_d;
         ex_alu_op_q    <= ex_alu_op_d;
         ex_funct3_q    <= ex_funct3_d;
         ex_use_imm_q   <= ex_use_imm_d;
         ex_use_pc_q    <= ex_use_pc_d;
         ex_reg_we_q    <= ex_reg_we_d;
         ex_is_load_q   <= ex_is_load_d;
         ex_is_store_q  <= ex_is_store_d;
         ex_is_branch_q <= ex_is_branch_d;
         ex_is_jal_q    <= ex_is_jal_d;
         ex_is_jalr_q   <= ex_is_jalr_d;
         ex_illegal_q   <= ex_illegal_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_pc        = ex_pc_q;
   assign ex_rd        = ex_rd_q;
   assign ex_rs1       = ex_rs1_q;
   assign ex_rs2       = ex_rs2_q;
   assign ex_imm       = ex_imm_q;
   assign ex_alu_op    = ex_alu_op_q;
   assign ex_funct3    = ex_funct3_q;
   assign ex_use_imm   = ex_use_imm_q;
   assign ex_use_pc    = ex_use_pc_q;
   assign ex_reg_we    = ex_reg_we_q;
   assign ex_is_load   = ex_is_load_q;
   assign ex_is_store  = ex_is_store_q;
   assign ex_is_branch = ex_is_branch_q;
   assign ex_is_jal    = ex_is_jal_q;
   assign ex_is_jalr   = ex_is_jalr_q;
   assign ex_illegal   = ex_illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboarded bench for id_decode_stage: directed cases, mid-stall reset, then randomized traffic.
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        flush;
   logic [4:0]  rf_rs1, rf_rs2;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [31:0] ex_imm;
   logic [3:0]  ex_alu_op;
   logic [2:0]  ex_funct3;
   logic        ex_use_imm, ex_use_pc, ex_reg_we;
   logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;

   id_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_use_imm(ex_use_imm),
      .ex_use_pc(ex_use_pc), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
      .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
      .ex_is_jalr(ex_is_jalr), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        imm_chk;
      logic [3:0]  alu;
      logic        alu_chk;
      logic [2:0]  f3;
      logic        use_imm, use_pc, we, load, store, branch, jal, jalr, illegal, u1, u2;
   } exp_t;

   exp_t        exp_q[$];
   bit          vld_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   bit          mon_en = 0;
   logic [31:0] pc_ctr = 32'h100;
   logic [3:0]  f3map [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
   logic [6:0]  opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h33, 7'h00};
   logic [6:0]  misc_tab [4] = '{7'h0F, 7'h73, 7'h7F, 7'h0B};

   // Model of the ID/EX occupancy needed to predict load-use stalls.
   bit          m_valid = 0;
   bit          m_load = 0;
   logic [4:0]  m_rd = 5'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      logic signed [31:0] s;
      logic [31:0] sgn;
      s   = ins;
      sgn = 32'(s >>> 31);
      e = '0;
      e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
      case (ins[6:0])
         7'h37: begin e.imm = ins & 32'hFFFFF000; e.imm_chk = 1; e.alu = 4'd10; e.alu_chk = 1;
                      e.use_imm = 1; e.we = 1; end
         7'h17: begin e.imm = ins & 32'hFFFFF000; e.imm_chk = 1; e.alu_chk = 1;
                      e.use_pc = 1; e.use_imm = 1; e.we = 1; end
         7'h6F: begin e.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                      e.imm_chk = 1; e.alu_chk = 1; e.use_pc = 1; e.we = 1; e.jal = 1; end
         7'h67: begin e.imm = 32'(s >>> 20); e.imm_chk = 1; e.alu_chk = 1;
                      e.use_pc = 1; e.we = 1; e.jalr = 1; e.u1 = 1; end
         7'h63: begin e.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                      e.imm_chk = 1; e.alu = 4'd1; e.alu_chk = 1; e.branch = 1; e.u1 = 1; e.u2 = 1; end
         7'h03: begin e.imm = 32'(s >>> 20); e.imm_chk = 1; e.alu_chk = 1;
                      e.use_imm = 1; e.we = 1; e.load = 1; e.u1 = 1; end
         7'h23: begin e.imm = ((sgn << 12) | (32'(ins[31:25]) << 5)) | 32'(ins[11:7]); e.imm_chk = 1;
                      e.alu_chk = 1; e.use_imm = 1; e.store = 1; e.u1 = 1; e.u2 = 1; end
         7'h13: begin e.imm = 32'(s >>> 20); e.imm_chk = 1; e.alu_chk = 1;
                      e.alu = (ins[14:12] == 3'd5 && ins[30]) ? 4'd7 : f3map[ins[14:12]];
                      e.use_imm = 1; e.we = 1; e.u1 = 1; end
         7'h33: begin e.alu_chk = 1;
                      if (ins[30] && ins[14:12] == 3'd0)      e.alu = 4'd1;
                      else if (ins[30] && ins[14:12] == 3'd5) e.alu = 4'd7;
                      else                                    e.alu = f3map[ins[14:12]];
                      e.we = 1; e.u1 = 1; e.u2 = 1; end
         7'h0F, 7'h73: e.alu_chk = 0;
         default: e.illegal = 1;
      endcase
      if (e.rd == 5'd0) e.we = 0;
      return e;
   endfunction

   // Drive one cycle's inputs, predict the handshake, push the expected EX content.
   task automatic drive_cycle(input bit v, input logic [31:0] ins, input bit fl, output bit acc);
      exp_t d;
      bit   stall, rdy, ev;
      if_valid = v; if_instr = ins; if_pc = pc_ctr; flush = fl;
      #1;
      d = ref_decode(ins, pc_ctr);
      stall = m_valid && m_load && (m_rd != 5'd0) && v &&
              ((d.u1 && d.rs1 == m_rd) || (d.u2 && d.rs2 == m_rd));
      rdy = fl || !stall;
      chk("if_ready", 32'(if_ready), 32'(rdy));
      chk("rf_rs1", 32'(rf_rs1), 32'(ins[19:15]));
      chk("rf_rs2", 32'(rf_rs2), 32'(ins[24:20]));
      ev = !fl && !stall && v;
      vld_q.push_back(ev);
      if (ev) begin
         exp_q.push_back(d);
         m_load = d.load;
         m_rd   = d.rd;
      end
      m_valid = ev;
      acc = v && rdy;
      if (acc) pc_ctr = pc_ctr + 32'd4;
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input bit fl, output bit acc);
      @(negedge clk);
      drive_cycle(v, ins, fl, acc);
   endtask

   task automatic send(input logic [31:0] ins, output int cycles);
      bit acc;
      cycles = 0;
      do begin
         step(1'b1, ins, 1'b0, acc);
         cycles++;
      end while (!acc && cycles < 8);
      if (!acc) chk("send_timeout", 32'(cycles), 32'd0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_outs();
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_illegal", 32'(ex_illegal), 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_ex_regs", 32'({ex_rd, ex_rs1, ex_rs2, ex_alu_op, ex_funct3}), 32'd0);
      chk("rst_ex_flags", 32'({ex_use_imm, ex_use_pc, ex_reg_we, ex_is_load, ex_is_store,
                               ex_is_branch, ex_is_jal, ex_is_jalr}), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd1);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      logic [6:0]  op;
      ins = $urandom;
      op  = opc_tab[$urandom_range(0, 11)];
      if (op == 7'h00) op = misc_tab[$urandom_range(0, 3)];
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      if (op == 7'h33) ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'b0};
      return ins;
   endfunction

   // Monitor: one expected-valid entry per post-reset cycle, plus a full record per valid instruction.
   initial begin
      exp_t e;
      bit   ev;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && rst_n) begin
            if (vld_q.size() == 0) begin
               chk("mon_underflow", 32'(vld_q.size()), 32'd1);
            end else begin
               ev = vld_q.pop_front();
               chk("ex_valid", 32'(ex_valid), 32'(ev));
               if (ev && ex_valid) begin
                  if (exp_q.size() == 0) chk("exp_underflow", 32'(exp_q.size()), 32'd1);
                  else begin
                     e = exp_q.pop_front();
                     chk("ex_pc", ex_pc, e.pc);
                     chk("ex_regs", 32'({ex_rd, ex_rs1, ex_rs2}), 32'({e.rd, e.rs1, e.rs2}));
                     chk("ex_funct3", 32'(ex_funct3), 32'(e.f3));
                     if (e.imm_chk) chk("ex_imm", ex_imm, e.imm);
                     if (e.alu_chk) begin
                        chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
                        chk("ex_use", 32'({ex_use_imm, ex_use_pc}), 32'({e.use_imm, e.use_pc}));
                     end
                     chk("ex_reg_we", 32'(ex_reg_we), 32'(e.we));
                     chk("ex_class", 32'({ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal}),
                         32'({e.load, e.store, e.branch, e.jal, e.jalr, e.illegal}));
                  end
               end else if (ev) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t, expected under 300000", $time);
      $fatal(1);
   end

   initial begin
      bit acc;
      bit held;
      int cyc;
      logic [31:0] cur;
      rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs();

      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b1, 32'hFFF08293, 1'b0, acc);   // addi x5,x1,-1
      mon_en = 1;
      after_edge();
      chk("addi_imm", ex_imm, 32'hFFFFFFFF);
      chk("addi_ctl", 32'({ex_alu_op, ex_use_imm, ex_reg_we, ex_rd}), 32'({4'd0, 1'b1, 1'b1, 5'd5}));
      send(32'hFE208EE3, cyc);                      // beq x1,x2,-4
      after_edge();
      chk("beq_imm", ex_imm, 32'hFFFFFFFC);
      chk("beq_ctl", 32'({ex_is_branch, ex_reg_we}), 32'({1'b1, 1'b0}));

      send(32'h0000A183, cyc);                      // lw x3,0(x1)
      send(32'h00218233, cyc);                      // add x4,x3,x2
      chk("load_use_cycles", 32'(cyc), 32'd2);
      after_edge();
      chk("load_use_add", 32'({ex_valid, ex_rd}), 32'({1'b1, 5'd4}));
      send(32'h0000A003, cyc);                      // lw x0,0(x1)
      send(32'h00200233, cyc);                      // add x4,x0,x2
      chk("lw_x0_cycles", 32'(cyc), 32'd1);

      step(1'b1, 32'h00208033, 1'b1, acc);          // flushed while valid
      chk("flush_consumed", 32'(acc), 32'd1);
      after_edge();
      chk("flush_bubble", 32'(ex_valid), 32'd0);
      send(32'h00208033, cyc);                      // add x0,x1,x2
      after_edge();
      chk("add_x0_we", 32'({ex_valid, ex_reg_we}), 32'({1'b1, 1'b0}));

      send(32'h0000A183, cyc);
      step(1'b1, 32'h00218233, 1'b1, acc);          // flush beats the load-use stall
      after_edge();
      chk("flush_stall_bubble", 32'(ex_valid), 32'd0);
      send(32'h00218233, cyc);
      chk("post_flush_cycles", 32'(cyc), 32'd1);

      send(32'h0000007F, cyc);                      // illegal opcode
      after_edge();
      chk("illegal", 32'({ex_valid, ex_illegal, ex_reg_we}), 32'({1'b1, 1'b1, 1'b0}));

      // Reset arriving mid-stall clears state at once; the held instruction follows after release.
      send(32'h0000A183, cyc);
      after_edge();
      mon_en = 0;
      @(negedge clk);
      if_valid = 1'b1; if_instr = 32'h00218233; if_pc = pc_ctr; flush = 1'b0;
      #1;
      chk("stall_before_reset", 32'(if_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk_reset_outs();
      vld_q.delete(); exp_q.delete();
      m_valid = 0; m_load = 0; m_rd = 5'd0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b1, 32'h00218233, 1'b0, acc);
      mon_en = 1;
      chk("reset_release_accept", 32'(acc), 32'd1);
      after_edge();
      chk("reset_release_ex", 32'({ex_valid, ex_rd}), 32'({1'b1, 5'd4}));

      held = 0;
      cur  = 32'h0;
      for (int i = 0; i < 1500; i++) begin
         bit v, fl;
         if (!held) cur = gen_instr();
         v  = held ? 1'b1 : ($urandom_range(0, 9) != 0);
         fl = ($urandom_range(0, 11) == 0);
         step(v, cur, fl, acc);
         held = v && !acc;
      end

      step(1'b0, 32'h0, 1'b0, acc);
      step(1'b0, 32'h0, 1'b0, acc);
      after_edge();
      mon_en = 0;
      chk("queues_drained", 32'(vld_q.size() + exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
